// File: rtl/time_field_pkg.sv
// Shared constants for the RTC time-field counters: BCD digit width,
// field moduli and default push-button auto-repeat timing.
package time_field_pkg;

   localparam int BCD_W           = 4;
   localparam int SEC_MOD         = 60;
   localparam int MIN_MOD         = 60;
   localparam int HOUR_MOD        = 24;
   localparam int REPEAT_DLY_DEF  = 50_000_000;
   localparam int REPEAT_RATE_DEF = 10_000_000;

   // Larger of two timing values; sizes the hold counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational binary to two-digit BCD conversion for values 0..99.
module bin2bcd_2dig
   import time_field_pkg::*;
#(
   parameter int W = 7
) (
   input  logic [W-1:0]     bin,
   output logic [BCD_W-1:0] digit1,
   output logic [BCD_W-1:0] digit0
);

   // Tens and units by constant division; inputs are bounded to 0..99.
   always_comb begin
      int unsigned v;
      v      = 32'(bin);
      digit1 = BCD_W'(v / 10);
      digit0 = BCD_W'(v % 10);
   end

endmodule

// File: rtl/bcd_updown_counter_mod.sv
// Up/down time-field counter, modulus MOD, with edge-detected push inputs,
// clamped parallel load, registered wrap pulses and 2-digit BCD output.
// Optional feature macro: AUTO_REPEAT_EN (held-button auto-repeat stepping).
module bcd_updown_counter_mod
   import time_field_pkg::*;
#(
   parameter int MOD         = SEC_MOD,
   parameter int W           = 7,
   parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
   parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             down,
   input  logic             load,
   input  logic [W-1:0]     load_val,
   output logic [W-1:0]     count,
   output logic [BCD_W-1:0] digit1,
   output logic [BCD_W-1:0] digit0,
   output logic             wrap_up,
   output logic             wrap_dn
);

   localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

   // Illegal parameter sets elaborate an extra marker block for visibility.
   if (MOD < 2 || MOD > 100 || (2 ** W) < MOD || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      localparam int BAD_CFG = 1;
   end

   logic up_q, dn_q;
   logic up_tick, dn_tick;
   logic rep_up, rep_dn;
   logic step_up, step_dn;

   assign up_tick = up & ~up_q;
   assign dn_tick = down & ~dn_q;

   // Previous-cycle levels for rising-edge detection, independent of en.
   always_ff @(posedge clk) begin
      if (reset) begin
         up_q <= 1'b0;
         dn_q <= 1'b0;
      end else begin
         up_q <= up;
         dn_q <= down;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int CW = $clog2(max_int(REPEAT_DLY, REPEAT_RATE) + 1);
   localparam logic [1:0] RPT_IDLE = 2'd0;
   localparam logic [1:0] RPT_DLY  = 2'd1;
   localparam logic [1:0] RPT_RATE = 2'd2;

   logic [1:0]    rpt_state;
   logic [CW-1:0] hold_cnt;
   logic          held, any_tick, rpt_fire;

   assign held     = en & (up ^ down) & ~load;
   assign any_tick = up_tick | dn_tick;
   // hold_cnt equals the number of cycles since the initial edge step (or since
   // the last repeat step), so a fresh edge restarts timing at cycle 0.
   assign rpt_fire = held & ~any_tick &
                     (((rpt_state == RPT_DLY)  && (hold_cnt == CW'(REPEAT_DLY))) ||
                      ((rpt_state == RPT_RATE) && (hold_cnt == CW'(REPEAT_RATE))));
   assign rep_up   = rpt_fire & up;
   assign rep_dn   = rpt_fire & down;

   // Hold timer: initial delay phase, then periodic repeat phase while held.
   always_ff @(posedge clk) begin
      if (reset || !held) begin
         rpt_state <= RPT_IDLE;
         hold_cnt  <= '0;
      end else if (any_tick) begin
         rpt_state <= RPT_DLY;
         hold_cnt  <= CW'(1);
      end else if (rpt_fire) begin
         rpt_state <= RPT_RATE;
         hold_cnt  <= CW'(1);
      end else begin
         rpt_state <= (rpt_state == RPT_IDLE) ? RPT_DLY : rpt_state;
         hold_cnt  <= hold_cnt + CW'(1);
      end
   end
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

   assign step_up = en & ((up_tick & ~dn_tick) | rep_up);
   assign step_dn = en & ((dn_tick & ~up_tick) | rep_dn);

   // Count register with load > step priority and one-cycle wrap pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
      end else begin
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
         if (load) begin
            count <= (32'(load_val) >= MOD) ? MAX_VAL : load_val;
         end else if (step_up) begin
            if (count == MAX_VAL) begin
               count   <= '0;
               wrap_up <= 1'b1;
            end else begin
               count <= count + W'(1);
            end
         end else if (step_dn) begin
            if (count == '0) begin
               count   <= MAX_VAL;
               wrap_dn <= 1'b1;
            end else begin
               count <= count - W'(1);
            end
         end
      end
   end

   bin2bcd_2dig #(.W(W)) u_bcd (
      .bin    (count),
      .digit1 (digit1),
      .digit0 (digit0)
   );

endmodule

// File: tb/tb_bcd_updown_counter_mod.sv
module tb_bcd_updown_counter_mod;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0, up = 1'b0, down = 1'b0, load = 1'b0;
   logic [6:0] load_val = '0;
   logic [6:0] count;
   logic [3:0] digit1, digit0;
   logic       wrap_up, wrap_dn;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int    c;
      int    d1;
      int    d0;
      int    wu;
      int    wd;
      string nm;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bcd_updown_counter_mod #(
      .MOD         (60),
      .W           (7),
      .REPEAT_DLY  (8),
      .REPEAT_RATE (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .down     (down),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .digit1   (digit1),
      .digit0   (digit0),
      .wrap_up  (wrap_up),
      .wrap_dn  (wrap_dn)
   );

   task automatic chk(input string nm, input string field, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, field, act, exp);
      end
   endtask

   task automatic push(input int c, input int d1, input int d0, input int wu, input int wd,
                       input string nm);
      exp_t e;
      e.c = c; e.d1 = d1; e.d0 = d0; e.wu = wu; e.wd = wd; e.nm = nm;
      sb.push_back(e);
   endtask

   // One cycle of stimulus; expected outputs after the following rising edge.
   task automatic drv(input logic e, input logic u, input logic d, input logic l,
                      input int lv, input int c, input int d1, input int d0,
                      input int wu, input int wd, input string nm);
      @(negedge clk);
      reset = 1'b0; en = e; up = u; down = d; load = l; load_val = 7'(lv);
      push(c, d1, d0, wu, wd, nm);
   endtask

   task automatic rst(input logic u, input string nm);
      @(negedge clk);
      reset = 1'b1; en = 1'b1; up = u; down = 1'b0; load = 1'b0; load_val = '0;
      push(0, 0, 0, 0, 0, nm);
   endtask

   // Monitor: outputs are presented every cycle; compare after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.nm, "count",   int'(count),   e.c);
            chk(e.nm, "digit1",  int'(digit1),  e.d1);
            chk(e.nm, "digit0",  int'(digit0),  e.d0);
            chk(e.nm, "wrap_up", int'(wrap_up), e.wu);
            chk(e.nm, "wrap_dn", int'(wrap_dn), e.wd);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      rst(1'b0, "reset0");
      rst(1'b0, "reset1");
      // three up pulses
      drv(1,1,0,0,0, 1,0,1,0,0, "up1");
      drv(1,0,0,0,0, 1,0,1,0,0, "up1rel");
      drv(1,1,0,0,0, 2,0,2,0,0, "up2");
      drv(1,0,0,0,0, 2,0,2,0,0, "up2rel");
      drv(1,1,0,0,0, 3,0,3,0,0, "up3");
      drv(1,0,0,0,0, 3,0,3,0,0, "up3rel");
      // load 59 then wrap up
      drv(1,0,0,1,59, 59,5,9,0,0, "load59");
      drv(1,1,0,0,0,  0,0,0,1,0, "wrapup");
      drv(1,0,0,0,0,  0,0,0,0,0, "wrapup_end");
      // down from 0 wraps
      drv(1,0,1,0,0, 59,5,9,0,1, "wrapdn");
      drv(1,0,0,0,0, 59,5,9,0,0, "wrapdn_end");
      drv(1,0,1,0,0, 58,5,8,0,0, "dn_plain");
      drv(1,0,0,0,0, 58,5,8,0,0, "dn_rel");
      // both edges together
      drv(1,0,0,1,30, 30,3,0,0,0, "load30");
      drv(1,1,1,0,0,  30,3,0,0,0, "both");
      drv(1,0,0,0,0,  30,3,0,0,0, "both_rel");
`ifndef AUTO_REPEAT_EN
      // long hold: only one step
      drv(1,1,0,0,0, 31,3,1,0,0, "hold_first");
      for (int i = 1; i < 100; i++) drv(1,1,0,0,0, 31,3,1,0,0, "hold");
      drv(1,0,0,0,0, 31,3,1,0,0, "hold_rel");
`else
      drv(1,1,0,0,0, 31,3,1,0,0, "up31");
      drv(1,0,0,0,0, 31,3,1,0,0, "up31rel");
`endif
      // edge while disabled is lost
      drv(0,1,0,0,0, 31,3,1,0,0, "en0_edge");
      drv(1,1,0,0,0, 31,3,1,0,0, "en1_still_high");
      drv(1,0,0,0,0, 31,3,1,0,0, "en_rel");
      // clamp and load priority
      drv(1,0,0,1,75, 59,5,9,0,0, "clamp75");
      drv(1,0,0,1,60, 59,5,9,0,0, "clamp60");
      drv(1,1,0,1,10, 10,1,0,0,0, "load_over_tick");
      drv(1,0,0,0,0,  10,1,0,0,0, "load_rel");
      // reset while held: tick after release
      drv(1,1,0,0,0, 11,1,1,0,0, "pre_rst_up");
      rst(1'b1, "rst_held");
      drv(1,1,0,0,0, 1,0,1,0,0, "post_rst_tick");
      drv(1,1,0,0,0, 1,0,1,0,0, "post_rst_hold");
      drv(1,0,0,0,0, 1,0,1,0,0, "post_rst_rel");
`ifdef AUTO_REPEAT_EN
      // repeat steps at hold cycles 0, 8, 12, 16, 20
      drv(1,0,0,1,58, 58,5,8,0,0, "rep_load58");
      for (int i = 0; i <= 20; i++) begin
         int v;
         v = (i < 8) ? 59 : (i < 12) ? 0 : (i < 16) ? 1 : (i < 20) ? 2 : 3;
         drv(1,1,0,0,0, v, v / 10, v % 10, (i == 8) ? 1 : 0, 0, "rep_hold");
      end
      for (int i = 0; i < 6; i++) drv(1,0,0,0,0, 3,0,3,0,0, "rep_rel");
`endif
      @(negedge clk);
      reset = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0;
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
